muldiv_unit: RTL

//   Iterative multiply/divide execution unit for the pipelined MIPS core, parametrised in width.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_step.sv | 37 +++
 rtl/muldiv_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit, also used by
// the control unit and the hazard logic.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

  function automatic logic is_signed_op(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div_op(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract
// for divide. Purely combinational.
module muldiv_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] q,
  input  logic [DATA_W-1:0] divisor,   // multiplicand when mode=0
  input  logic              mode,      // 1 = divide
  output logic [DATA_W-1:0] acc_next,
  output logic [DATA_W-1:0] q_next
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] shifted;
  logic            fits;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_next = acc;
    q_next   = q;
    sum      = {1'b0, acc} + {1'b0, (q[0] ? divisor : '0)};
    shifted  = {acc, q[DATA_W-1]};
    fits     = shifted >= {1'b0, divisor};
    if (mode) begin
      // Remainder after a successful subtract is below the divisor, so the
      // DATA_W-bit difference is exact.
      acc_next = fits ? (shifted[DATA_W-1:0] - divisor) : shifted[DATA_W-1:0];
      q_next   = {q[DATA_W-2:0], fits};
    end else begin
      acc_next = sum[DATA_W:1];
      q_next   = {sum[0], q[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EXE stage. Runs DATA_W radix-2
// steps, then a fixup cycle that applies signs and writes HI/LO.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc, q, opnd, a_raw;
  logic              is_div, sign_a, sign_b, b_zero;

  op_e               op_in;
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] mag_a, mag_b;
  logic [DATA_W-1:0] acc_nxt, q_nxt;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0] res_hi, res_lo;

  assign op_in = op_e'(op);
  assign a_neg = is_signed_op(op_in) && operand_a[DATA_W-1];
  assign b_neg = is_signed_op(op_in) && operand_b[DATA_W-1];
  // MIN_NEG negates to itself, which is still the right unsigned magnitude.
  assign mag_a = a_neg ? -operand_a : operand_a;
  assign mag_b = b_neg ? -operand_b : operand_b;

  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .acc      (acc),
    .q        (q),
    .divisor  (opnd),
    .mode     (is_div),
    .acc_next (acc_nxt),
    .q_next   (q_nxt)
  );

  // Sign fixup and divide-by-zero handling, consumed in FIX.
  always_comb begin
    prod   = {acc, q};
    res_hi = '0;
    res_lo = '0;
    if (!is_div) begin
      if (sign_a ^ sign_b) prod = -prod;
      {res_hi, res_lo} = prod;
    end else if (b_zero) begin
      res_hi = a_raw;
      res_lo = '1;
    end else begin
      res_lo = (sign_a ^ sign_b) ? -q : q;
      res_hi = sign_a ? -acc : acc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      q      <= '0;
      opnd   <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (enable) begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !flush) begin
            state  <= RUN;
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            is_div <= is_div_op(op_in);
            sign_a <= a_neg;
            sign_b <= b_neg;
            a_raw  <= operand_a;
            b_zero <= (operand_b == '0);
            // Divide shifts the dividend out of q; multiply shifts the multiplier.
            q      <= is_div_op(op_in) ? mag_a : mag_b;
            opnd   <= is_div_op(op_in) ? mag_b : mag_a;
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= acc_nxt;
            q   <= q_nxt;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_STEP) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
